seg7_num_formatter: RTL

Converts a 32-bit binary value into the eight per-digit codes consumed by the 8-digit multiplexed 7-segment tube driver. Its outputs p0..p7 connect directly to that driver's p0..p7 inputs. Hex mode is a direct nibble split. Decimal mode uses a sequential double-dabble binary-to-BCD conversion, one bit per clock. Outputs are double-buffered, so the display never shows a partial conversion.

---
 rtl/seg7_num_formatter_if.sv | 22 ++
 rtl/seg7_num_formatter.sv | 110 +++++++++++
 2 files changed

// File: rtl/seg7_num_formatter_if.sv
// Request/result bundle between a producer of numbers and the 7-segment formatter.
// The master side requests a conversion; the slave side returns eight digit codes.
interface seg7_num_formatter_if;
  logic        start;
  logic [31:0] value;
  logic        hex_mode;
  logic        blank_lz;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [7:0]  p0, p1, p2, p3, p4, p5, p6, p7;

  modport master (
    output start, value, hex_mode, blank_lz,
    input  busy, done, overflow, p0, p1, p2, p3, p4, p5, p6, p7
  );

  modport slave (
    input  start, value, hex_mode, blank_lz,
    output busy, done, overflow, p0, p1, p2, p3, p4, p5, p6, p7
  );
endinterface

// File: rtl/seg7_num_formatter.sv
// Formats a 32-bit value into eight tube-driver digit codes, either as hex nibbles or
// as decimal via a one-bit-per-clock double-dabble; results are double-buffered.
module seg7_num_formatter #(
  parameter logic [7:0] BLANK_CODE = 8'hFF,
  parameter logic [7:0] ERR_CODE   = 8'h0E
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seg7_num_formatter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, CONV, FMT} state_t;

  state_t      state;
  logic [31:0] shift_q;
  logic [39:0] bcd_q;
  logic [4:0]  iter_q;
  logic        hex_q;
  logic        blz_q;
  logic        done_q;
  logic        ovf_q;
  logic [7:0]  p_q [8];

  logic [39:0] bcd_adj;
  logic [3:0]  digit [8];
  logic [7:0]  code [8];
  logic        ovf_next;
  logic        keep_blank;

  always_comb begin
    bcd_adj = bcd_q;
    for (int n = 0; n < 10; n++) begin
      if (bcd_q[4*n +: 4] >= 4'd5)
        bcd_adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
    end
  end

  // In hex mode the shift register still holds the captured value, so it doubles as the nibble source.
  always_comb begin
    ovf_next   = !hex_q && (bcd_q[39:32] != 8'h00);
    keep_blank = blz_q;
    code       = '{default: BLANK_CODE};
    for (int n = 0; n < 8; n++)
      digit[n] = hex_q ? shift_q[4*n +: 4] : bcd_q[4*n +: 4];
    for (int n = 7; n >= 0; n--) begin
      if (digit[n] != 4'h0 || n == 0)
        keep_blank = 1'b0;
      if (ovf_next)
        code[n] = ERR_CODE;
      else if (keep_blank)
        code[n] = BLANK_CODE;
      else
        code[n] = {4'h0, digit[n]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shift_q <= '0;
      bcd_q   <= '0;
      iter_q  <= '0;
      hex_q   <= 1'b0;
      blz_q   <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      p_q     <= '{default: BLANK_CODE};
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            shift_q <= bus.value;
            hex_q   <= bus.hex_mode;
            blz_q   <= bus.blank_lz;
            bcd_q   <= '0;
            iter_q  <= '0;
            state   <= bus.hex_mode ? FMT : CONV;
          end
        end
        CONV: begin
          {bcd_q, shift_q} <= {bcd_adj[38:0], shift_q, 1'b0};
          iter_q           <= iter_q + 5'd1;
          if (iter_q == 5'd31)
            state <= FMT;
        end
        FMT: begin
          p_q    <= code;
          ovf_q  <= ovf_next;
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;
  assign bus.p0       = p_q[0];
  assign bus.p1       = p_q[1];
  assign bus.p2       = p_q[2];
  assign bus.p3       = p_q[3];
  assign bus.p4       = p_q[4];
  assign bus.p5       = p_q[5];
  assign bus.p6       = p_q[6];
  assign bus.p7       = p_q[7];

endmodule
